acc_cpu_core: RTL and testbench
===============================

// Module: acc_cpu_core
// PURPOSE
//   Parametrised accumulator CPU core: the next generation of the 8-bit CPU top.
//   Holds its own instruction and data memories, loaded through a byte-style load port.
//   Runs a 16-opcode ISA through a two-state fetch/execute sequencer.
//   Sits directly under the TinyTapeout top, which only maps ui_in/uo_out/uio pins onto
//   these ports.
// PARAMETERS
//   DATA_W  8  accumulator / data-memory word width (>=4)
//   ADDR_W  4  address width; IMEM and DMEM depth = 2**ADDR_W; instruction width IW = 4+ADDR_W
// PORTS
//   clk        in   1       clock, all state updates on rising edge
//   rst        in   1       synchronous, active-high reset
//   load_en    in   1       write strobe for the load port (honoured only in IDLE/HALT)
//   load_sel   in   1       0 = write IMEM, 1 = write DMEM
//   load_addr  in   ADDR_W  load target address
//   load_data  in   IW      load word; DMEM uses bits [DATA_W-1:0] when DATA_W<=IW, else zero-extended
//   run        in   1       start pulse; sampled in IDLE/HALT only
//   busy       out  1       1 in FETCH/EXEC
//   halted     out  1       1 in HALT
//   pc         out  ADDR_W  current program counter
//   out_data   out  DATA_W  last value emitted by OUT; holds between OUTs
//   out_valid  out  1       one-cycle pulse in the EXEC cycle of an OUT instruction
// BEHAVIOUR
//   Reset: state=IDLE, pc=0, acc=0, Z=0, C=0, ir=0, out_data=0, out_valid=0, busy=0, halted=0.
//   Memories are not reset; contents survive rst. DMEM is only ever zero-extended from the load
//   port — never sign-extended or truncated when DATA_W > IW.
//   FSM states are IDLE, FETCH, EXEC, HALT.
//     IDLE/HALT: load_en writes mem[load_sel][load_addr] this edge.
//       run=1 -> FETCH, with pc=0, acc=0, Z=0, C=0.
//       load_en and run in the same cycle: the write lands AND the run starts.
//     FETCH: ir <= IMEM[pc] (combinational array read); pc <= pc+1 (mod 2**ADDR_W) -> EXEC.
//     EXEC: execute ir; -> FETCH, except HLT -> HALT.
//     load_en and run are ignored in FETCH/EXEC.
//   Timing: every instruction takes exactly 2 cycles; no stalls.
//   Instruction format: ir[IW-1:ADDR_W] = opcode, ir[ADDR_W-1:0] = a (address or immediate).
//   Opcodes (M = DMEM[a], width DATA_W, wrap arithmetic):
//     0 NOP | 1 LDA acc=M | 2 STA M=acc | 3 ADD acc=acc+M, C=carry | 4 SUB acc=acc-M, C=borrow(acc<M)
//     5 LDI acc=zext(a) | 6 JMP pc=a | 7 JZ pc=a if Z | 8 JC pc=a if C | 9 OUT out_data=acc, out_valid=1
//     10 AND | 11 OR | 12 XOR (acc op M) | 13 SHL C=acc[msb], acc<<1 | 14 SHR C=acc[0], acc>>1 | 15 HLT
//   Flag updates:
//     Z = (new acc==0) after opcodes 1,3,4,5,10-14; other opcodes leave Z unchanged.
//     C is written by opcodes 3,4,13,14 only.
//   JZ/JC test flags as they were at the start of EXEC. Jumps overwrite the incremented pc.
//     Not-taken jumps fall through.
//   PC wrap: pc wraps from 2**ADDR_W-1 to 0 with no fault. Programs without HLT loop forever.
//   rst mid-run: returns to IDLE next edge; any STA in that EXEC cycle is not committed.
// STRUCTURE
//   Shared package cpu_pkg holds:
//     - opcode localparams OP_NOP..OP_HLT (4 bits)
//     - state encoding ST_IDLE/ST_FETCH/ST_EXEC/ST_HALT (2 bits)
//   One sub-module: acc_alu (combinational, DATA_W param).
//     Inputs: op, acc, M, a. Outputs: result, carry, zero, wr_acc, wr_c, wr_z.
//   The sequencer, pc, ir and memories stay in acc_cpu_core.
// TESTING  (DATA_W=8, ADDR_W=4 unless noted)
//   1. Load DMEM[0]=5, DMEM[1]=7; program LDA 0, ADD 1, OUT, HLT; run.
//        -> out_valid exactly once with out_data=12; halted after 8 cycles; C=0.
//   2. DMEM[0]=200, DMEM[1]=100; program LDA 0, ADD 1, JC 5, … ; at 5: OUT, HLT.
//        -> out_data=44, C=1, branch taken, pc path 0,1,2,5,6.
//   3. Countdown: LDI 3; loop SUB one; OUT; JZ end; JMP loop; end: HLT.
//        -> out_data sequence 2,1,0, then halted.
//   4. Program with no HLT (16 NOPs); run.
//        -> pc wraps 15 -> 0 and busy stays 1.
//      load_en during run: no IMEM change (readback via a later halted run).
//   5. Assert rst during an EXEC of STA 3 (acc=9).
//        -> DMEM[3] unchanged, state IDLE, all outputs at reset values next cycle.
//   6. DATA_W=12, ADDR_W=6: LDI 63, SHL, SHL, OUT.
//        -> out_data=252 (0x0FC), C=0.
//      load_en+run in the same cycle: the write is visible to the first fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode values and sequencer state encoding.
package cpu_pkg;

    // 4-bit opcodes, taken from ir[IW-1:ADDR_W]
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_STA = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JZ  = 4'd7;
    localparam logic [3:0] OP_JC  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd9;
    localparam logic [3:0] OP_AND = 4'd10;
    localparam logic [3:0] OP_OR  = 4'd11;
    localparam logic [3:0] OP_XOR = 4'd12;
    localparam logic [3:0] OP_SHL = 4'd13;
    localparam logic [3:0] OP_SHR = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator CPU.
// Ports:
//   i_op        opcode of the instruction in EXEC
//   i_acc       current accumulator
//   i_m         DMEM[a] operand
//   i_a         address/immediate field of the instruction
//   o_result_c  new accumulator value (valid when o_wr_acc_c)
//   o_carry_c   new C flag (valid when o_wr_c_c)
//   o_zero_c    o_result_c == 0 (valid when o_wr_z_c)
//   o_wr_acc_c  opcode writes the accumulator
//   o_wr_c_c    opcode writes C
//   o_wr_z_c    opcode writes Z
module acc_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_m,
    input  logic [ADDR_W-1:0] i_a,
    output logic [DATA_W-1:0] o_result_c,
    output logic              o_carry_c,
    output logic              o_zero_c,
    output logic              o_wr_acc_c,
    output logic              o_wr_c_c,
    output logic              o_wr_z_c
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // Extra top bit carries out of ADD; for SUB it is the borrow (acc < M)
    assign w_sum  = (DATA_W+1)'(i_acc) + (DATA_W+1)'(i_m);
    assign w_diff = (DATA_W+1)'(i_acc) - (DATA_W+1)'(i_m);

    always_comb begin
        o_result_c = i_acc;
        o_carry_c  = 1'b0;
        o_wr_acc_c = 1'b0;
        o_wr_c_c   = 1'b0;
        case (i_op)
            OP_LDA: begin
                o_result_c = i_m;
                o_wr_acc_c = 1'b1;
            end
            OP_ADD: begin
                o_result_c = w_sum[DATA_W-1:0];
                o_carry_c  = w_sum[DATA_W];
                o_wr_acc_c = 1'b1;
                o_wr_c_c   = 1'b1;
            end
            OP_SUB: begin
                o_result_c = w_diff[DATA_W-1:0];
                o_carry_c  = w_diff[DATA_W];
                o_wr_acc_c = 1'b1;
                o_wr_c_c   = 1'b1;
            end
            OP_LDI: begin
                o_result_c = DATA_W'(i_a);
                o_wr_acc_c = 1'b1;
            end
            OP_AND: begin
                o_result_c = i_acc & i_m;
                o_wr_acc_c = 1'b1;
            end
            OP_OR: begin
                o_result_c = i_acc | i_m;
                o_wr_acc_c = 1'b1;
            end
            OP_XOR: begin
                o_result_c = i_acc ^ i_m;
                o_wr_acc_c = 1'b1;
            end
            OP_SHL: begin
                o_result_c = {i_acc[DATA_W-2:0], 1'b0};
                o_carry_c  = i_acc[DATA_W-1];
                o_wr_acc_c = 1'b1;
                o_wr_c_c   = 1'b1;
            end
            OP_SHR: begin
                o_result_c = {1'b0, i_acc[DATA_W-1:1]};
                o_carry_c  = i_acc[0];
                o_wr_acc_c = 1'b1;
                o_wr_c_c   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Every accumulator-writing opcode also refreshes Z
    assign o_wr_z_c = o_wr_acc_c;
    assign o_zero_c = (o_result_c == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core with private IMEM/DMEM, a load port and a fetch/execute sequencer.
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   load_en     load-port write strobe (acts only in IDLE/HALT)
//   load_sel    0 = IMEM, 1 = DMEM
//   load_addr   load target address
//   load_data   load word (DMEM takes it truncated/zero-extended to DATA_W)
//   run         start pulse (acts only in IDLE/HALT)
//   busy        1 in FETCH/EXEC
//   halted      1 in HALT
//   pc          program counter
//   out_data    last value emitted by OUT
//   out_valid   one-cycle pulse during the EXEC cycle of OUT
module acc_cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic                load_sel,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [ADDR_W+3:0]   load_data,
    input  logic                run,
    output logic                busy,
    output logic                halted,
    output logic [ADDR_W-1:0]   pc,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid
);

    localparam int unsigned IW    = 4 + ADDR_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [IW-1:0]     r_imem [DEPTH];
    logic [DATA_W-1:0] r_dmem [DEPTH];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [IW-1:0]     r_ir;
    logic [DATA_W-1:0] r_acc;
    logic              r_z;
    logic              r_c;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_halted;

    logic [IW-1:0]     w_fetch_word;
    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_m;
    logic              w_stopped;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic              w_alu_zero;
    logic              w_alu_wr_acc;
    logic              w_alu_wr_c;
    logic              w_alu_wr_z;

    assign w_fetch_word = r_imem[r_pc];
    assign w_op         = r_ir[IW-1:ADDR_W];
    assign w_a          = r_ir[ADDR_W-1:0];
    assign w_m          = r_dmem[w_a];
    assign w_stopped    = (r_state == ST_IDLE) || (r_state == ST_HALT);

    acc_alu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_alu (
        .i_op       (w_op),
        .i_acc      (r_acc),
        .i_m        (w_m),
        .i_a        (w_a),
        .o_result_c (w_alu_result),
        .o_carry_c  (w_alu_carry),
        .o_zero_c   (w_alu_zero),
        .o_wr_acc_c (w_alu_wr_acc),
        .o_wr_c_c   (w_alu_wr_c),
        .o_wr_z_c   (w_alu_wr_z)
    );

    // Sequencer next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: if (run) w_state_nxt = ST_FETCH;
            ST_FETCH:         w_state_nxt = ST_EXEC;
            ST_EXEC:          w_state_nxt = (w_op == OP_HLT) ? ST_HALT : ST_FETCH;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus the status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_EXEC);
            r_halted <= (w_state_nxt == ST_HALT);
        end
    end

    // Datapath: pc, ir, accumulator, flags and output port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (run) begin
                        r_pc  <= '0;
                        r_acc <= '0;
                        r_z   <= 1'b0;
                        r_c   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_ir <= w_fetch_word;
                    r_pc <= r_pc + ADDR_W'(1);
                    // OUT is captured at fetch so the pulse lines up with its EXEC cycle;
                    // acc cannot change between fetch and execute of OUT.
                    if (w_fetch_word[IW-1:ADDR_W] == OP_OUT) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc;
                    end
                end
                ST_EXEC: begin
                    if (w_alu_wr_acc) r_acc <= w_alu_result;
                    if (w_alu_wr_z)   r_z   <= w_alu_zero;
                    if (w_alu_wr_c)   r_c   <= w_alu_carry;
                    // Branch conditions use the flags held at the start of EXEC
                    if ((w_op == OP_JMP) || ((w_op == OP_JZ) && r_z) || ((w_op == OP_JC) && r_c)) begin
                        r_pc <= w_a;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memories: load port when stopped, STA in EXEC; not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (w_stopped && load_en) begin
            if (load_sel) r_dmem[load_addr] <= DATA_W'(load_data);
            else          r_imem[load_addr] <= load_data;
        end else if (!rst && (r_state == ST_EXEC) && (w_op == OP_STA)) begin
            r_dmem[w_a] <= r_acc;
        end
    end

    assign busy      = r_busy;
    assign halted    = r_halted;
    assign pc        = r_pc;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: instruction-level reference model expanded into
// per-cycle expectations for an 8/4 instance, plus directed checks on a 12/6 instance.
module tb_acc_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit / 4-bit-address instance
    logic       rst = 1'b1, load_en = 1'b0, load_sel = 1'b0, run = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       busy, halted, out_valid;
    logic [3:0] pc;
    logic [7:0] out_data;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .run(run),
        .busy(busy), .halted(halted), .pc(pc), .out_data(out_data), .out_valid(out_valid)
    );

    // 12-bit / 6-bit-address instance
    logic        rst2 = 1'b1, le2 = 1'b0, ls2 = 1'b0, run2 = 1'b0;
    logic [5:0]  la2 = '0;
    logic [9:0]  ld2 = '0;
    logic        busy2, halted2, ov2;
    logic [5:0]  pc2;
    logic [11:0] od2;

    acc_cpu_core #(.DATA_W(12), .ADDR_W(6)) dut12 (
        .clk(clk), .rst(rst2), .load_en(le2), .load_sel(ls2),
        .load_addr(la2), .load_data(ld2), .run(run2),
        .busy(busy2), .halted(halted2), .pc(pc2), .out_data(od2), .out_valid(ov2)
    );

    typedef struct {
        int pc;
        int busy;
        int halted;
        int ov;
        int od;
    } rec_t;

    rec_t exp_q[$];
    int   outs_seen[$];
    int   imem_m [16];
    int   dmem_m [16];
    int   m_out = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Per-cycle compare against the model's expected trace; also records OUT values
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) outs_seen.push_back(int'(out_data));
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("pc",        int'(pc),        r.pc);
                chk("busy",      int'(busy),      r.busy);
                chk("halted",    int'(halted),    r.halted);
                chk("out_valid", int'(out_valid), r.ov);
                chk("out_data",  int'(out_data),  r.od);
            end
        end
    end

    // Instruction-level model: each instruction shows a fetch cycle then an execute cycle.
    // A trace cut at `limit` stops before the cut instruction takes effect (reset follows).
    task automatic build_trace(input int limit, output int nrec, output bit hlt);
        int p, acc, z, c, cyc, ins, op, a, mm, npc, s;
        bit jmp;
        p = 0; acc = 0; z = 0; c = 0; cyc = 0; hlt = 1'b0;
        while (cyc < limit && !hlt) begin
            ins = imem_m[p]; op = (ins >> 4) & 15; a = ins & 15; mm = dmem_m[a];
            exp_q.push_back('{p, 1, 0, 0, m_out});
            cyc++;
            if (cyc >= limit) break;
            npc = (p + 1) % 16;
            if (op == 9) m_out = acc;
            exp_q.push_back('{npc, 1, 0, (op == 9) ? 1 : 0, m_out});
            cyc++;
            if (cyc >= limit) break;
            jmp = 1'b0;
            case (op)
                1:  acc = mm;
                2:  dmem_m[a] = acc;
                3:  begin s = acc + mm; c = (s > 255) ? 1 : 0; acc = s & 255; end
                4:  begin c = (acc < mm) ? 1 : 0; acc = (acc - mm) & 255; end
                5:  acc = a;
                6:  jmp = 1'b1;
                7:  jmp = (z != 0);
                8:  jmp = (c != 0);
                10: acc = acc & mm;
                11: acc = acc | mm;
                12: acc = acc ^ mm;
                13: begin c = (acc >> 7) & 1; acc = (acc << 1) & 255; end
                14: begin c = acc & 1; acc = acc >> 1; end
                15: hlt = 1'b1;
                default: ;
            endcase
            if (op inside {1, 3, 4, 5, [10:14]}) z = (acc == 0) ? 1 : 0;
            p = jmp ? a : npc;
        end
        if (hlt) begin
            exp_q.push_back('{p, 0, 1, 0, m_out});
            cyc++;
        end
        nrec = cyc;
    endtask

    task automatic load8(input bit sel, input int addr, input int data);
        @(negedge clk);
        load_en = 1'b1; load_sel = sel; load_addr = 4'(addr); load_data = 8'(data);
        @(posedge clk);
        #1 load_en = 1'b0;
        if (sel) dmem_m[addr] = data & 255;
        else     imem_m[addr] = data & 255;
    endtask

    // Leaves the caller at a negedge inside the last expected cycle
    task automatic run_prog(input int limit, input bit poke, output int nrec, output bit hlt);
        @(negedge clk);
        build_trace(limit, nrec, hlt);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 1; i < nrec; i++) begin
            if (poke) begin
                load_en = 1'b1; load_sel = 1'($urandom);
                load_addr = 4'($urandom); load_data = 8'($urandom);
            end
            @(negedge clk);
        end
        load_en = 1'b0;
    endtask

    // Caller is at a negedge; rst covers exactly the next rising edge
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_out = 0;
        chk("rst_busy",   int'(busy),      0);
        chk("rst_halted", int'(halted),    0);
        chk("rst_pc",     int'(pc),        0);
        chk("rst_ov",     int'(out_valid), 0);
        chk("rst_od",     int'(out_data),  0);
    endtask

    task automatic load12(input bit sel, input int addr, input int data);
        @(negedge clk);
        le2 = 1'b1; ls2 = sel; la2 = 6'(addr); ld2 = 10'(data);
        @(posedge clk);
        #1 le2 = 1'b0;
    endtask

    task automatic wait_halt12(output int nov);
        nov = 0;
        for (int i = 0; i < 60 && !halted2; i++) begin
            @(negedge clk);
            if (ov2) nov++;
        end
        chk("t6_halted", int'(halted2), 1);
    endtask

    initial begin
        int  n, nov;
        bit  h;
        int  prog1 [4] = '{8'h10, 8'h31, 8'h90, 8'hF0};
        int  prog2 [7] = '{8'h10, 8'h31, 8'h85, 8'hF0, 8'hF0, 8'h90, 8'hF0};
        int  prog3 [6] = '{8'h53, 8'h41, 8'h90, 8'h75, 8'h61, 8'hF0};
        int  prog6 [9] = '{10'h3C0, 10'h340, 10'h340, 10'h240, 10'h206,
                           10'h3C0, 10'h141, 10'h240, 10'h3C0};

        for (int i = 0; i < 16; i++) begin imem_m[i] = 0; dmem_m[i] = 0; end
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 16; i++) begin load8(0, i, 0); load8(1, i, 0); end

        // 1: 5 + 7
        load8(1, 0, 5); load8(1, 1, 7);
        for (int i = 0; i < 4; i++) load8(0, i, prog1[i]);
        outs_seen.delete();
        run_prog(100, 0, n, h);
        chk("t1_len", n, 9);
        chk("t1_nout", outs_seen.size(), 1);
        if (outs_seen.size() > 0) chk("t1_out", outs_seen[0], 12);
        chk("t1_halted", int'(halted), 1);

        // 2: 200 + 100 carries, JC taken to 5
        load8(1, 0, 200); load8(1, 1, 100);
        for (int i = 0; i < 7; i++) load8(0, i, prog2[i]);
        outs_seen.delete();
        run_prog(100, 0, n, h);
        chk("t2_nout", outs_seen.size(), 1);
        if (outs_seen.size() > 0) chk("t2_out", outs_seen[0], 44);
        chk("t2_pc", int'(pc), 7);

        // 3: countdown 2,1,0
        load8(1, 1, 1);
        for (int i = 0; i < 6; i++) load8(0, i, prog3[i]);
        outs_seen.delete();
        run_prog(200, 0, n, h);
        chk("t3_nout", outs_seen.size(), 3);
        for (int i = 0; i < 3 && i < outs_seen.size(); i++) chk("t3_out", outs_seen[i], 2 - i);

        // 4: all NOPs wrap forever; load port pokes during the run must be ignored
        for (int i = 0; i < 16; i++) load8(0, i, 0);
        run_prog(40, 1, n, h);
        chk("t4_running", int'(h), 0);
        do_reset();
        load8(0, 15, 8'hF0);
        run_prog(100, 0, n, h);
        chk("t4_len", n, 33);

        // 5: reset lands on the EXEC edge of STA 3
        load8(1, 3, 8'h55);
        load8(0, 0, 8'h59); load8(0, 1, 8'h23); load8(0, 2, 8'hF0);
        run_prog(4, 0, n, h);
        do_reset();
        load8(0, 0, 8'h13); load8(0, 1, 8'h90); load8(0, 2, 8'hF0);
        outs_seen.delete();
        run_prog(100, 0, n, h);
        chk("t5_nout", outs_seen.size(), 1);
        if (outs_seen.size() > 0) chk("t5_dmem3", outs_seen[0], 8'h55);

        // Random programs against the model
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 16; i++) begin
                load8(1, i, int'($urandom_range(0, 255)));
                load8(0, i, int'($urandom_range(0, 255)));
            end
            run_prog(60, 0, n, h);
            if (!h) do_reset();
        end

        // 6: wide instance; IMEM[0] written in the same cycle as run
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 9; i++) load12(0, i, prog6[i]);
        @(negedge clk);
        le2 = 1'b1; ls2 = 1'b0; la2 = 6'd0; ld2 = 10'h17F; run2 = 1'b1;
        @(negedge clk);
        le2 = 1'b0; run2 = 1'b0;
        wait_halt12(nov);
        chk("t6_out", int'(od2), 252);
        chk("t6_pc", int'(pc2), 6);
        chk("t6_nout", nov, 1);

        // DMEM word wider than the load port is zero-extended
        load12(1, 2, 10'h3FF);
        load12(0, 0, 10'h042); load12(0, 1, 10'h240); load12(0, 2, 10'h3C0);
        @(negedge clk);
        run2 = 1'b1;
        @(negedge clk);
        run2 = 1'b0;
        wait_halt12(nov);
        chk("t6_zext", int'(od2), 12'h3FF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
